crc32_frame_ctrl: RTL and testbench

CRC32_FRAME_CTRL -- requirements
Module: crc32_frame_ctrl

---
 rtl/crc32_frame_ctrl.sv | 172 +++++++++++++++++
 tb/tb_crc32_frame_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc32_frame_ctrl.sv
// Byte-stream to serial CRC32 engine controller: one bit per clock, LSB first, one-byte skid.
// Optional CRC32_FRAME_CTRL_CHECK_EN adds exp_crc/res_match for in-line CRC comparison.
module crc32_frame_ctrl #(
    parameter int unsigned MAX_LEN = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [7:0]  s_data,
    input  logic        s_last,
    output logic        crc_clr,
    output logic        crc_din,
    input  logic [31:0] crc_val,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_crc,
    output logic [15:0] res_len,
    output logic        res_err
`ifdef CRC32_FRAME_CTRL_CHECK_EN
    ,
    input  logic [31:0] exp_crc,
    output logic        res_match
`endif
);

    localparam logic [15:0] MaxLen = 16'(MAX_LEN);

    typedef enum logic [1:0] {StIdle, StShift, StCapt, StDone} state_t;

    state_t      state_q, state_d;
    logic [7:0]  sh_q, sh_d;
    logic [2:0]  idx_q, idx_d;
    logic [15:0] len_q, len_d, len_inc;
    logic        cur_last_q, cur_last_d;
    logic [7:0]  hold_q, hold_d;
    logic        hold_full_q, hold_full_d;
    logic        hold_last_q, hold_last_d;
    logic        err_q, err_d;
    logic        drain_q, drain_d;
    logic        rdy;
    logic [31:0] res_crc_q;
    logic [15:0] res_len_q;
    logic        res_err_q;

    assign len_inc = (len_q == MaxLen) ? len_q : len_q + 16'd1;

    always_comb begin
        state_d     = state_q;
        sh_d        = sh_q;
        idx_d       = idx_q;
        len_d       = len_q;
        cur_last_d  = cur_last_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        hold_last_d = hold_last_q;
        err_d       = err_q;
        drain_d     = drain_q;
        rdy         = 1'b0;
        crc_clr     = 1'b1;
        crc_din     = 1'b0;
        res_valid   = 1'b0;
        unique case (state_q)
            StIdle: begin
                rdy = 1'b1;
                if (s_valid) begin
                    // After an underrun, swallow the rest of the aborted frame.
                    if (drain_q) begin
                        if (s_last) drain_d = 1'b0;
                    end else begin
                        sh_d       = s_data;
                        idx_d      = 3'd0;
                        len_d      = 16'd1;
                        cur_last_d = s_last;
                        err_d      = 1'b0;
                        state_d    = StShift;
                    end
                end
            end
            StShift: begin
                crc_clr = 1'b0;
                crc_din = sh_q[idx_q];
                rdy     = !hold_full_q && !cur_last_q;
                idx_d   = idx_q + 3'd1;
                if (idx_q != 3'd7) begin
                    if (s_valid && rdy) begin
                        hold_d      = s_data;
                        hold_full_d = 1'b1;
                        hold_last_d = s_last;
                    end
                end else if (cur_last_q) begin
                    state_d = StCapt;
                end else if (hold_full_q) begin
                    sh_d        = hold_q;
                    cur_last_d  = hold_last_q;
                    hold_full_d = 1'b0;
                    len_d       = len_inc;
                end else if (s_valid) begin
                    sh_d       = s_data;
                    cur_last_d = s_last;
                    len_d      = len_inc;
                end else begin
                    err_d   = 1'b1;
                    drain_d = 1'b1;
                    state_d = StCapt;
                end
            end
            StCapt: begin
                state_d = StDone;
            end
            StDone: begin
                res_valid = 1'b1;
                if (res_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Ready is forced low while reset is asserted even though the state reads IDLE.
    assign s_ready = rdy & rst_n;
    assign res_crc = res_crc_q;
    assign res_len = res_len_q;
    assign res_err = res_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            sh_q        <= 8'd0;
            idx_q       <= 3'd0;
            len_q       <= 16'd0;
            cur_last_q  <= 1'b0;
            hold_q      <= 8'd0;
            hold_full_q <= 1'b0;
            hold_last_q <= 1'b0;
            err_q       <= 1'b0;
            drain_q     <= 1'b0;
            res_crc_q   <= 32'd0;
            res_len_q   <= 16'd0;
            res_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            cur_last_q  <= cur_last_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            hold_last_q <= hold_last_d;
            err_q       <= err_d;
            drain_q     <= drain_d;
            if (state_q == StCapt) begin
                res_crc_q <= ~crc_val;
                res_len_q <= len_q;
                res_err_q <= err_q;
            end
        end
    end

`ifdef CRC32_FRAME_CTRL_CHECK_EN
    logic res_match_q;
    assign res_match = res_match_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_match_q <= 1'b0;
        end else if (state_q == StCapt) begin
            res_match_q <= (~crc_val == exp_crc) && !err_q;
        end
    end
`endif

endmodule

// File: tb/tb_crc32_frame_ctrl.sv
// Bench for crc32_frame_ctrl: models the serial CRC engine and checks every result against
// a byte-level CRC32 reference plus directed literal expectations.
module tb_crc32_frame_ctrl;

    localparam int unsigned MaxLen = 12;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [7:0]  s_data = 8'd0;
    logic        s_last = 1'b0;
    logic        crc_clr;
    logic        crc_din;
    logic [31:0] crc_val;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic [31:0] res_crc;
    logic [15:0] res_len;
    logic        res_err;
`ifdef CRC32_FRAME_CTRL_CHECK_EN
    logic [31:0] chk_crc = 32'd0;
    logic        res_match;
`endif

    always #5 clk = ~clk;

    crc32_frame_ctrl #(.MAX_LEN(MaxLen)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .crc_clr   (crc_clr),
        .crc_din   (crc_din),
        .crc_val   (crc_val),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_crc   (res_crc),
        .res_len   (res_len),
        .res_err   (res_err)
`ifdef CRC32_FRAME_CTRL_CHECK_EN
        ,
        .exp_crc   (chk_crc),
        .res_match (res_match)
`endif
    );

    // Serial reflected CRC32 engine, one bit per clock, registered output.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) crc_val <= 32'hFFFF_FFFF;
        else if (crc_clr) crc_val <= 32'hFFFF_FFFF;
        else crc_val <= (crc_val >> 1) ^ ((crc_val[0] ^ crc_din) ? 32'hEDB8_8320 : 32'd0);
    end

    int checks = 0;
    int failures = 0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endfunction

    function automatic logic [31:0] crc32_ref(input logic [7:0] b[$]);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        foreach (b[i]) begin
            c = c ^ {24'd0, b[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return ~c;
    endfunction

    logic [31:0] mq_crc[$];
    logic [31:0] mq_len[$];
    logic [31:0] mq_err[$];

    function automatic void expect_frame(input logic [7:0] b[$], input logic err);
        int unsigned n;
        n = b.size();
        mq_crc.push_back(crc32_ref(b));
        mq_len.push_back(32'(n > MaxLen ? MaxLen : n));
        mq_err.push_back(32'(err));
    endfunction

    always @(negedge clk) begin
        if (rst_n && res_valid) begin
            if (mq_crc.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result: res_valid=1 with no frame outstanding");
            end else begin
                check("model_crc", res_crc, mq_crc[0]);
                check("model_len", 32'(res_len), mq_len[0]);
                check("model_err", 32'(res_err), mq_err[0]);
            end
        end
    end

    always @(posedge clk) begin
        if (rst_n && res_valid && res_ready && mq_crc.size() > 0) begin
            void'(mq_crc.pop_front());
            void'(mq_len.pop_front());
            void'(mq_err.pop_front());
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push(input logic [7:0] d, input logic last);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        while (!s_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("push_accept", 32'(s_ready), 32'd1);
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send(input logic [7:0] b[$]);
        foreach (b[i]) push(b[i], i == b.size() - 1);
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!res_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({name, "_valid"}, 32'(res_valid), 32'd1);
    endtask

    task automatic wait_result(input string name, input logic [31:0] crc,
                               input logic [15:0] len, input logic err);
        wait_valid(name);
        if (res_valid) begin
            check({name, "_crc"}, res_crc, crc);
            check({name, "_len"}, 32'(res_len), 32'(len));
            check({name, "_err"}, 32'(res_err), 32'(err));
        end
        res_ready = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] str[$];
        logic [7:0] zero[$];
        logic [7:0] pair[$];
        logic [7:0] gapf[$];
        logic [7:0] satf[$];
        int k;
        int cnt;
        str  = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        zero = '{8'h00};
        pair = '{8'h31, 8'h32};
        gapf = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        for (int i = 0; i < 16; i++) satf.push_back(8'(i * 37 + 5));

        repeat (3) @(negedge clk);
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_crc_clr", 32'(crc_clr), 32'd1);
        check("rst_crc_din", 32'(crc_din), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_crc", res_crc, 32'd0);
        check("rst_res_len", 32'(res_len), 32'd0);
        check("rst_res_err", 32'(res_err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_s_ready", 32'(s_ready), 32'd1);
        check("idle_crc_clr", 32'(crc_clr), 32'd1);

        check("ref_check_string", crc32_ref(str), 32'hCBF4_3926);
        check("ref_zero_byte", crc32_ref(zero), 32'hD202_EF8D);

        // Reference string, back-to-back
        expect_frame(str, 1'b0);
        send(str);
        wait_result("t_check", 32'hCBF4_3926, 16'd9, 1'b0);

        // Single zero byte with latency measurement
        expect_frame(zero, 1'b0);
        push(8'h00, 1'b1);
        k = 1;
        while (!res_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("t_single_latency", 32'(k), 32'd10);
        wait_result("t_single", 32'hD202_EF8D, 16'd1, 1'b0);

        // Underrun after two bytes, then drain the tail and run a clean frame
        res_ready = 1'b0;
        expect_frame(pair, 1'b1);
        push(8'h31, 1'b0);
        push(8'h32, 1'b0);
        repeat (20) @(negedge clk);
        wait_result("t_underrun", crc32_ref(pair), 16'd2, 1'b1);
        for (int i = 2; i < 9; i++) push(str[i], i == 8);
        expect_frame(str, 1'b0);
        send(str);
        wait_result("t_after_drain", 32'hCBF4_3926, 16'd9, 1'b0);

        // Result back-pressure with the next frame pending
        res_ready = 1'b0;
        expect_frame(str, 1'b0);
        send(str);
        wait_valid("t_stall_first");
        s_valid = 1'b1;
        s_data  = 8'h31;
        s_last  = 1'b0;
        cnt = 0;
        repeat (50) begin
            @(negedge clk);
            if (s_ready) cnt++;
        end
        check("t_stall_ready_cycles", 32'(cnt), 32'd0);
        check("t_stall_hold_valid", 32'(res_valid), 32'd1);
        check("t_stall_hold_crc", res_crc, 32'hCBF4_3926);
        check("t_stall_hold_len", 32'(res_len), 32'd9);
        res_ready = 1'b1;
        expect_frame(str, 1'b0);
        send(str);
        wait_result("t_stall_next", 32'hCBF4_3926, 16'd9, 1'b0);

        // Input gaps absorbed by the holding register
        expect_frame(gapf, 1'b0);
        foreach (gapf[i]) begin
            push(gapf[i], i == 3);
            if (i != 3) repeat (3) @(negedge clk);
        end
        wait_result("t_gaps", crc32_ref(gapf), 16'd4, 1'b0);

        // Length saturation at MAX_LEN
        expect_frame(satf, 1'b0);
        send(satf);
        wait_result("t_saturate", crc32_ref(satf), 16'(MaxLen), 1'b0);

        // Reset in the middle of a frame
        for (int i = 0; i < 4; i++) push(str[i], 1'b0);
        rst_n = 1'b0;
        #1;
        check("t_midrst_s_ready", 32'(s_ready), 32'd0);
        check("t_midrst_crc_clr", 32'(crc_clr), 32'd1);
        check("t_midrst_crc_din", 32'(crc_din), 32'd0);
        check("t_midrst_res_valid", 32'(res_valid), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("t_midrst_no_result", 32'(res_valid), 32'd0);
        expect_frame(str, 1'b0);
        send(str);
        wait_result("t_midrst_next", 32'hCBF4_3926, 16'd9, 1'b0);

`ifdef CRC32_FRAME_CTRL_CHECK_EN
        res_ready = 1'b0;
        chk_crc = 32'hCBF4_3926;
        expect_frame(str, 1'b0);
        send(str);
        wait_valid("t_match_hit");
        check("t_match_hit", 32'(res_match), 32'd1);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk_crc = 32'd0;
        expect_frame(str, 1'b0);
        send(str);
        wait_valid("t_match_miss");
        check("t_match_miss", 32'(res_match), 32'd0);
        res_ready = 1'b1;
        @(negedge clk);
`endif

        repeat (5) @(negedge clk);
        check("model_queue_empty", 32'(mq_crc.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
